bsr_sipo_rx: RTL and testbench
==============================

Name: bsr_sipo_rx

Overview:
Bidirectional serial-in/parallel-out receiver. It is the receive end of the bidirectional PISO shift-register link.
- Collects WIDTH serial bits, MSB-first (mode=1) or LSB-first (mode=0), matching the transmitter's left and right shift modes.
- Presents the assembled word on a held parallel output with a one-cycle valid pulse.
- Sits between the serial link and the consuming parallel logic.

Parameters:
WIDTH, 4, number of data bits per word (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
mode  input  1  1 = MSB-first (left shift), 0 = LSB-first (right shift)
en  input  1  bit strobe; sin is sampled only on cycles with en=1
sin  input  1  serial data in
clr  input  1  synchronous word-abort; drops a partial word
pout  output  WIDTH  last completed word, held until the next completion
valid  output  1  one-cycle pulse when pout is updated
busy  output  1  high while a word is partially received
perr  output  1  parity error flag (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at posedge):
  - shift register = 0, bit counter = 0, latched mode = 0.
  - pout = 0, valid = 0, busy = 0, perr = 0.
  - rst has priority over every other input.
- Internal state:
  - shift[WIDTH-1:0].
  - cnt, counting 0..WIDTH-1 (0..WIDTH with parity).
  - mode_l, the latched direction.
- Mode latching:
  - On an en cycle with cnt==0, the shifter uses mode directly and stores it in mode_l.
  - Bits with cnt!=0 use mode_l. Changes on mode mid-word are ignored until the next word.
- Shift on en=1, clr=0:
  - Left (MSB-first): shift <= {shift[WIDTH-2:0], sin}.
  - Right (LSB-first): shift <= {sin, shift[WIDTH-1:1]}.
  - cnt increments.
- en=0: shift and cnt hold; valid=0.
- Word completion (en=1 with cnt==WIDTH-1, no parity build):
  - pout <= the new shifted value, including this sin.
  - valid <= 1 at the same edge, so valid and pout change together.
  - cnt <= 0.
  - Latency: valid is high in the cycle after the clock edge that samples the last bit.
- valid is high for exactly one cycle per completed word. It is cleared on the following edge unless another word completes, which needs WIDTH>=2 en cycles, so back-to-back valids are impossible.
- Back-to-back words: continuous en is allowed. The bit after completion starts a new word (cnt==0) and re-samples mode.
- clr=1 (rst=0):
  - shift <= 0, cnt <= 0.
  - pout is held; valid <= 0.
  - clr has priority over en, and a sin bit on that cycle is discarded.
- busy = (cnt != 0), decoded from registered cnt.
- Reset or clr mid-word: the partial word is lost and valid never pulses for it.

Optional Feature:
Macro BSR_SIPO_PARITY_EN.
- Defined:
  - Each word carries one extra even-parity bit after the WIDTH data bits, sampled on the (WIDTH+1)th en cycle.
  - That bit does not enter shift; cnt runs 0..WIDTH.
  - pout and valid update at the parity-bit edge, not at the last data bit. Latency grows by one bit strobe.
  - perr <= (^data) ^ parity_bit at that edge. perr is held until the next valid or rst; clr does not change it.
  - busy stays high while waiting for the parity bit.
- Undefined: perr is tied to 0 and behaviour is as described above.

Test Plan:
1. WIDTH=4, rst for 2 cycles, then mode=1, en=1 for four cycles with sin=1,0,1,1 -> one cycle after the 4th edge: pout=4'b1011, valid=1 for exactly 1 cycle, busy=0.
2. mode=0, sin=1,0,1,1 -> pout=4'b1101, valid pulse once.
3. Same stream as scenario 1 with en=0 gaps of 1–3 cycles between bits, sin toggling during the gaps -> pout=4'b1011, single valid; busy=1 from the first bit until completion.
4. mode=1 for the first bit, then mode=0 for the rest, sin=1,1,0,0 -> pout=4'b1100 (latched MSB-first); the next word then uses mode=0.
5. Two bits received, then clr=1 with en=1 -> no valid and pout unchanged. Then mode=1, sin=0,1,1,0 -> pout=4'b0110.
   - Repeat with rst asserted after 3 bits -> pout=0, valid never asserts, busy=0.
6. With BSR_SIPO_PARITY_EN defined, mode=1:
   - sin=1,0,1,1 then parity=1 -> pout=4'b1011, valid=1, perr=0.
   - Same data with parity=0 -> perr=1.
   - No valid is allowed at the 4th data bit.

Source files
------------

// File: rtl/bsr_sipo_rx.sv
// bsr_sipo_rx: serial-in/parallel-out receiver, MSB- or LSB-first.
// Optional per-word even parity under `BSR_SIPO_PARITY_EN.
//
// Ports:
//   clk   - system clock, all logic on posedge
//   rst   - synchronous active-high reset
//   mode  - 1 = MSB-first (left shift), 0 = LSB-first (right shift)
//   en    - bit strobe, sin sampled only when high
//   sin   - serial data in
//   clr   - synchronous word abort, drops a partial word
//   pout  - last completed word, held until the next completion
//   valid - one-cycle pulse when pout updates
//   busy  - high while a word is partially received
//   perr  - parity error of the last word (0 without parity)
module bsr_sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             en,
    input  logic             sin,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             valid,
    output logic             busy,
    output logic             perr
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cnt;
    logic             mode_l;
    logic             dir;

    // First bit of a word uses the live mode; the rest use the latched copy.
    always_comb begin
        dir       = (cnt == '0) ? mode : mode_l;
        shift_nxt = dir ? {shift[WIDTH-2:0], sin}
                        : {sin, shift[WIDTH-1:1]};
    end

    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift  <= '0;
            cnt    <= '0;
            mode_l <= 1'b0;
            pout   <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr) begin
                shift <= '0;
                cnt   <= '0;
            end else if (en) begin
                if (cnt == '0)
                    mode_l <= mode;
`ifdef BSR_SIPO_PARITY_EN
                // Parity strobe: the bit is checked, not shifted in.
                if (cnt == CW'(WIDTH)) begin
                    pout  <= shift;
                    valid <= 1'b1;
                    cnt   <= '0;
                end else begin
                    shift <= shift_nxt;
                    cnt   <= cnt + 1'b1;
                end
`else
                shift <= shift_nxt;
                if (cnt == CW'(WIDTH - 1)) begin
                    pout  <= shift_nxt;
                    valid <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
            end
        end
    end

`ifdef BSR_SIPO_PARITY_EN
    // Held until the next completed word; clr leaves it alone.
    always_ff @(posedge clk) begin
        if (rst)
            perr <= 1'b0;
        else if (!clr && en && cnt == CW'(WIDTH))
            perr <= (^shift) ^ sin;
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_bsr_sipo_rx.sv
// tb_bsr_sipo_rx: vector table plus valid/pout scoreboard for bsr_sipo_rx.
// Parity sequences run when BSR_SIPO_PARITY_EN is defined.
module tb_bsr_sipo_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       en = 1'b0;
    logic       sin = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] pout;
    logic       valid;
    logic       busy;
    logic       perr;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic       r;
        logic       c;
        logic       e;
        logic       m;
        logic       s;
        logic       ev;
        logic       eb;
        logic       ep;
        logic [3:0] epo;
    } vec_t;

    vec_t       tv[$];
    logic [3:0] sb[$];

    bsr_sipo_rx #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .en    (en),
        .sin   (sin),
        .clr   (clr),
        .pout  (pout),
        .valid (valid),
        .busy  (busy),
        .perr  (perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] got,
                         input logic [6:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s: got v/b/p/pout=%b want %b", name, got, exp);
    endtask

    // Scoreboard side: every valid pulse must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: valid with pout=%b, none expected",
                         pout);
            end else begin
                logic [3:0] w;
                w = sb.pop_front();
                if (pout === w)
                    passes++;
                else
                    $display("FAIL sb_word: got pout=%b want %b", pout, w);
            end
        end
    end

    task automatic step(input string name, input logic r, input logic c,
                        input logic e, input logic m, input logic s,
                        input logic ev, input logic eb, input logic ep,
                        input logic [3:0] epo);
        @(negedge clk);
        rst  = r;
        clr  = c;
        en   = e;
        mode = m;
        sin  = s;
        if (ev)
            sb.push_back(epo);
        @(posedge clk);
        #1;
        check(name, {valid, busy, perr, pout}, {ev, eb, ep, epo});
    endtask

    function automatic void add(input logic r, input logic c, input logic e,
                                input logic m, input logic s, input logic ev,
                                input logic eb, input logic [3:0] epo);
        vec_t v;
        v = '{r, c, e, m, s, ev, eb, 1'b0, epo};
        tv.push_back(v);
    endfunction

    task automatic sb_drained(input string name);
        checks++;
        if (sb.size() == 0)
            passes++;
        else
            $display("FAIL %s: got %0d words pending want 0", name, sb.size());
    endtask

    initial begin
`ifndef BSR_SIPO_PARITY_EN
        //  r  c  e  m  s  ev eb pout
        add(1, 0, 0, 0, 0, 0, 0, 4'b0000);
        add(1, 0, 1, 1, 1, 0, 0, 4'b0000);
        // MSB-first 1011
        add(0, 0, 1, 1, 1, 0, 1, 4'b0000);
        add(0, 0, 1, 1, 0, 0, 1, 4'b0000);
        add(0, 0, 1, 1, 1, 0, 1, 4'b0000);
        add(0, 0, 1, 1, 1, 1, 0, 4'b1011);
        add(0, 0, 0, 1, 0, 0, 0, 4'b1011);
        // LSB-first 1,0,1,1 -> 1101
        add(0, 0, 1, 0, 1, 0, 1, 4'b1011);
        add(0, 0, 1, 0, 0, 0, 1, 4'b1011);
        add(0, 0, 1, 0, 1, 0, 1, 4'b1011);
        add(0, 0, 1, 0, 1, 1, 0, 4'b1101);
        add(0, 0, 0, 0, 0, 0, 0, 4'b1101);
        // MSB-first 1011 with en gaps, sin toggling in gaps
        add(0, 0, 1, 1, 1, 0, 1, 4'b1101);
        add(0, 0, 0, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 1, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 0, 1, 1, 0, 1, 4'b1101);
        add(0, 0, 0, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 1, 1, 1, 0, 1, 4'b1101);
        add(0, 0, 0, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 0, 1, 1, 0, 1, 4'b1101);
        add(0, 0, 0, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 1, 1, 1, 1, 0, 4'b1011);
        add(0, 0, 0, 1, 0, 0, 0, 4'b1011);
        // mode latched MSB-first; later mode changes ignored
        add(0, 0, 1, 1, 1, 0, 1, 4'b1011);
        add(0, 0, 1, 0, 1, 0, 1, 4'b1011);
        add(0, 0, 1, 0, 0, 0, 1, 4'b1011);
        add(0, 0, 1, 0, 0, 1, 0, 4'b1100);
        // next word picks up mode=0, back-to-back
        add(0, 0, 1, 0, 1, 0, 1, 4'b1100);
        add(0, 0, 1, 0, 0, 0, 1, 4'b1100);
        add(0, 0, 1, 0, 1, 0, 1, 4'b1100);
        add(0, 0, 1, 0, 1, 1, 0, 4'b1101);
        // continuous en, MSB-first 1001 then LSB-first 1,1,0,0 -> 0011
        add(0, 0, 1, 1, 1, 0, 1, 4'b1101);
        add(0, 0, 1, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 1, 1, 0, 0, 1, 4'b1101);
        add(0, 0, 1, 1, 1, 1, 0, 4'b1001);
        add(0, 0, 1, 0, 1, 0, 1, 4'b1001);
        add(0, 0, 1, 0, 1, 0, 1, 4'b1001);
        add(0, 0, 1, 0, 0, 0, 1, 4'b1001);
        add(0, 0, 1, 0, 0, 1, 0, 4'b0011);
        add(0, 0, 0, 0, 0, 0, 0, 4'b0011);

        for (int i = 0; i < tv.size(); i++)
            step($sformatf("vec%0d", i), tv[i].r, tv[i].c, tv[i].e,
                 tv[i].m, tv[i].s, tv[i].ev, tv[i].eb, tv[i].ep, tv[i].epo);

        // clr with en mid-word drops the partial word, pout held
        step("clr_b0",  0, 0, 1, 1, 1, 0, 1, 0, 4'b0011);
        step("clr_b1",  0, 0, 1, 1, 0, 0, 1, 0, 4'b0011);
        step("clr_hit", 0, 1, 1, 1, 1, 0, 0, 0, 4'b0011);
        step("clr_idl", 0, 0, 0, 1, 1, 0, 0, 0, 4'b0011);
        step("w_b0",    0, 0, 1, 1, 0, 0, 1, 0, 4'b0011);
        step("w_b1",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0011);
        step("w_b2",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0011);
        step("w_b3",    0, 0, 1, 1, 0, 1, 0, 0, 4'b0110);
        // rst after 3 bits: everything cleared, no valid
        step("r_b0",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0110);
        step("r_b1",    0, 0, 1, 1, 0, 0, 1, 0, 4'b0110);
        step("r_b2",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0110);
        step("r_hit",   1, 0, 1, 1, 1, 0, 0, 0, 4'b0000);
        step("r_idl0",  0, 0, 0, 1, 1, 0, 0, 0, 4'b0000);
        step("r_idl1",  0, 0, 0, 1, 0, 0, 0, 0, 4'b0000);
`else
        step("rst0",    1, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("rst1",    1, 0, 1, 1, 1, 0, 0, 0, 4'b0000);
        // 1011 + parity 1: even, no error
        step("p_b0",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0000);
        step("p_b1",    0, 0, 1, 1, 0, 0, 1, 0, 4'b0000);
        step("p_b2",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0000);
        step("p_b3",    0, 0, 1, 1, 1, 0, 1, 0, 4'b0000);
        step("p_par",   0, 0, 1, 1, 1, 1, 0, 0, 4'b1011);
        step("p_idl",   0, 0, 0, 1, 0, 0, 0, 0, 4'b1011);
        // same data, parity 0: error
        step("q_b0",    0, 0, 1, 1, 1, 0, 1, 0, 4'b1011);
        step("q_b1",    0, 0, 1, 1, 0, 0, 1, 0, 4'b1011);
        step("q_b2",    0, 0, 1, 1, 1, 0, 1, 0, 4'b1011);
        step("q_b3",    0, 0, 1, 1, 1, 0, 1, 0, 4'b1011);
        step("q_gap",   0, 0, 0, 1, 0, 0, 1, 0, 4'b1011);
        step("q_par",   0, 0, 1, 1, 0, 1, 0, 1, 4'b1011);
        // clr keeps perr
        step("c_b0",    0, 0, 1, 1, 0, 0, 1, 1, 4'b1011);
        step("c_hit",   0, 1, 1, 1, 1, 0, 0, 1, 4'b1011);
        // 0110 + parity 0: error clears
        step("z_b0",    0, 0, 1, 1, 0, 0, 1, 1, 4'b1011);
        step("z_b1",    0, 0, 1, 1, 1, 0, 1, 1, 4'b1011);
        step("z_b2",    0, 0, 1, 1, 1, 0, 1, 1, 4'b1011);
        step("z_b3",    0, 0, 1, 1, 0, 0, 1, 1, 4'b1011);
        step("z_par",   0, 0, 1, 1, 0, 1, 0, 0, 4'b0110);
        step("z_idl",   0, 0, 0, 1, 0, 0, 0, 0, 4'b0110);
`endif
        sb_drained("sb_empty");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
